// File: rtl/dmem_pkg.sv
// dmem_pkg: types and constants shared by the data-memory arbiter and its grant logic.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    // Requester identifiers, also used as the round-robin pointer encoding.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    // Width of the memory latency down-counter; MEM_LAT may be 1..15.
    localparam int LAT_CNT_W = 4;

    // A word access is misaligned when either low byte-address bit is set.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU port, debug/loader port and memory-side bus of the data-memory arbiter.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;

    logic              dbg_req;
    logic              dbg_we;
    logic [31:0]       dbg_addr;
    logic [31:0]       dbg_wdata;
    logic [31:0]       dbg_rdata;
    logic              dbg_ready;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic              err_misalign;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output err_misalign
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  err_misalign
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: two-way grant selection between the CPU and debug ports.
// Build option DMEM_ARB_RR_EN: when defined, ties alternate through a 1-bit
// round-robin pointer; when undefined, the debug port always wins a tie.
module dmem_arb_pick
    import dmem_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
    input  logic clk,
    input  logic rst,
    input  logic advance,
`endif
    input  logic cpu_req,
    input  logic dbg_req,
    output logic win_valid,
    output logic win_id
);

    assign win_valid = cpu_req | dbg_req;

`ifdef DMEM_ARB_RR_EN
    logic ptr;

    // A lone requester wins outright; a tie goes to whichever side the pointer names.
    always_comb begin
        win_id = ptr;
        if (cpu_req && !dbg_req) begin
            win_id = REQ_CPU;
        end else if (dbg_req && !cpu_req) begin
            win_id = REQ_DBG;
        end
    end

    // After every grant the pointer moves to the loser so the next tie goes the other way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= REQ_CPU;
        end else if (advance) begin
            ptr <= ~win_id;
        end
    end
`else
    // Fixed priority: the debug/loader port beats the CPU whenever both ask.
    always_comb begin
        win_id = REQ_CPU;
        if (dbg_req) begin
            win_id = REQ_DBG;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU load/store port and the
// debug/loader port. Each access is IDLE -> ACCESS (MEM_LAT+1 cycles) -> DONE, with a
// one-cycle ready pulse to the winner in DONE. Misaligned accesses skip the memory,
// return 0 and set a sticky error flag. Build option DMEM_ARB_RR_EN selects
// round-robin arbitration instead of fixed debug-over-CPU priority.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 1
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(MEM_LAT);

    arb_state_t           state;
    arb_state_t           state_nx;
    logic [LAT_CNT_W-1:0] lat_cnt;

    logic                 win_valid;
    logic                 win_id;
    logic                 win_we;
    logic [31:0]          win_addr;
    logic [31:0]          win_wdata;
    logic                 win_mis;
    logic                 grant;

    logic                 lat_id;
    logic                 lat_we;
    logic [ADDR_W-1:0]    lat_addr;
    logic [31:0]          lat_wdata;

    logic [31:0]          cpu_rdata_q;
    logic [31:0]          dbg_rdata_q;
    logic                 err_q;

    logic                 unused_addr_hi;

    dmem_arb_pick u_pick (
`ifdef DMEM_ARB_RR_EN
        .clk       (clk),
        .rst       (rst),
        .advance   (grant),
`endif
        .cpu_req   (bus.cpu_req),
        .dbg_req   (bus.dbg_req),
        .win_valid (win_valid),
        .win_id    (win_id)
    );

    assign win_we    = (win_id == REQ_DBG) ? bus.dbg_we    : bus.cpu_we;
    assign win_addr  = (win_id == REQ_DBG) ? bus.dbg_addr  : bus.cpu_addr;
    assign win_wdata = (win_id == REQ_DBG) ? bus.dbg_wdata : bus.cpu_wdata;
    assign win_mis   = is_misaligned(win_addr[1:0]);
    assign grant     = (state == IDLE) && win_valid;

    // Byte-address bits above the RAM size are dropped, so addresses wrap.
    assign unused_addr_hi = ^win_addr[31:ADDR_W+2];

    assign bus.cpu_rdata    = cpu_rdata_q;
    assign bus.dbg_rdata    = dbg_rdata_q;
    assign bus.err_misalign = err_q;

    // State register; reset drops straight back to IDLE, abandoning any access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state plus memory strobe and ready pulses, all decoded from the current state.
    always_comb begin
        state_nx      = state;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = lat_addr;
        bus.mem_wdata = lat_wdata;
        bus.cpu_ready = 1'b0;
        bus.dbg_ready = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_nx = win_mis ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (lat_cnt == LAT_INIT) begin
                    bus.mem_en = 1'b1;
                    bus.mem_we = lat_we;
                end
                if (lat_cnt == '0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx      = IDLE;
                bus.cpu_ready = (lat_id == REQ_CPU);
                bus.dbg_ready = (lat_id == REQ_DBG);
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Latch the winner's request at grant, count down the memory latency, and capture read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_id      <= REQ_CPU;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_cnt     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            err_q       <= 1'b0;
        end else if (grant) begin
            lat_id    <= win_id;
            lat_we    <= win_we;
            lat_addr  <= win_addr[ADDR_W+1:2];
            lat_wdata <= win_wdata;
            lat_cnt   <= LAT_INIT;
            if (win_mis) begin
                err_q <= 1'b1;
                if (win_id == REQ_DBG) begin
                    dbg_rdata_q <= '0;
                end else begin
                    cpu_rdata_q <= '0;
                end
            end
        end else if (state == ACCESS) begin
            if (lat_cnt != '0) begin
                lat_cnt <= lat_cnt - LAT_CNT_W'(1);
            end else if (!lat_we) begin
                if (lat_id == REQ_DBG) begin
                    dbg_rdata_q <= bus.mem_rdata;
                end else begin
                    cpu_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter. One instance runs with MEM_LAT=1
// behind a single-cycle RAM model, a second with MEM_LAT=4 behind a four-stage pipelined
// RAM model. Expected ready/rdata pairs are queued when a request is driven and popped
// whenever the MEM_LAT=1 instance pulses a ready.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int          AW   = 10;
    localparam logic [31:0] FILL = 32'hBAD0_BAD0;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        rst;

    int          n_checks = 0;
    int          n_fail   = 0;

    sb_entry_t   sb_q[$];
    sb_entry_t   mon_e;
    logic [31:0] ref_mem [0:1023];
    logic [31:0] exp_cpu_rdata;
    logic [31:0] exp_dbg_rdata;

    int          en_cnt;
    int          dbg_ready_cnt;
    logic        last_we;
    logic [AW-1:0] last_addr;
    logic [31:0] last_wdata;

    logic [31:0] mem1 [0:1023];
    logic [31:0] rd1;
    logic [31:0] mem4 [0:1023];
    logic [31:0] p4 [0:3];

    int          en_base;
    int          dbg_base;
    int          pulses;
    int          cyc;

    dmem_arbiter_if #(.ADDR_W(AW)) bus1 ();
    dmem_arbiter_if #(.ADDR_W(AW)) bus4 ();

    dmem_arbiter #(.ADDR_W(AW), .MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    dmem_arbiter #(.ADDR_W(AW), .MEM_LAT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Single-cycle synchronous RAM; reads outside the valid cycle return a filler pattern.
    always @(posedge clk) begin
        if (bus1.mem_en && bus1.mem_we) begin
            mem1[bus1.mem_addr] <= bus1.mem_wdata;
        end
        rd1 <= (bus1.mem_en && !bus1.mem_we) ? mem1[bus1.mem_addr] : FILL;
    end
    assign bus1.mem_rdata = rd1;

    // Four-stage read pipeline: data is valid exactly four cycles after mem_en.
    always @(posedge clk) begin
        p4[0] <= (bus4.mem_en && !bus4.mem_we) ? mem4[bus4.mem_addr] : FILL;
        for (int k = 1; k < 4; k++) begin
            p4[k] <= p4[k-1];
        end
    end
    assign bus4.mem_rdata = p4[3];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Memory-side monitor and scoreboard consumer for the MEM_LAT=1 instance.
    always @(negedge clk) begin
        if (bus1.mem_en) begin
            en_cnt     <= en_cnt + 1;
            last_we    <= bus1.mem_we;
            last_addr  <= bus1.mem_addr;
            last_wdata <= bus1.mem_wdata;
        end
        if (bus1.dbg_ready) begin
            dbg_ready_cnt <= dbg_ready_cnt + 1;
        end
        if (bus1.cpu_ready || bus1.dbg_ready) begin
            if (sb_q.size() == 0) begin
                checkOutput("sb_unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("sb_winner", 32'(bus1.dbg_ready), 32'(mon_e.id));
                checkOutput("sb_single_ready", 32'(bus1.cpu_ready & bus1.dbg_ready), 32'd0);
                checkOutput("sb_rdata", mon_e.id ? bus1.dbg_rdata : bus1.cpu_rdata, mon_e.data);
            end
        end
    end

    function automatic logic ready_of(input logic id);
        return id ? bus1.dbg_ready : bus1.cpu_ready;
    endfunction

    // Reference model: computes the rdata a requester must show with its ready and queues it.
    task automatic expect_access(input logic id, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        sb_entry_t   e;
        logic [9:0]  w;
        w = addr[11:2];
        if (addr[1:0] != 2'b00) begin
            if (id) exp_dbg_rdata = '0;
            else    exp_cpu_rdata = '0;
        end else if (we) begin
            ref_mem[w] = wdata;
        end else begin
            if (id) exp_dbg_rdata = ref_mem[w];
            else    exp_cpu_rdata = ref_mem[w];
        end
        e.id   = id;
        e.data = id ? exp_dbg_rdata : exp_cpu_rdata;
        sb_q.push_back(e);
    endtask

    task automatic drive_req(input logic id, input logic req, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (id) begin
            bus1.dbg_req = req; bus1.dbg_we = we; bus1.dbg_addr = addr; bus1.dbg_wdata = wdata;
        end else begin
            bus1.cpu_req = req; bus1.cpu_we = we; bus1.cpu_addr = addr; bus1.cpu_wdata = wdata;
        end
    endtask

    // One complete access on the MEM_LAT=1 instance, checking latency and pulse width.
    task automatic applyStimulus(input string tag, input logic id, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int exp_cycles);
        int cycles;
        @(negedge clk);
        expect_access(id, we, addr, wdata);
        drive_req(id, 1'b1, we, addr, wdata);
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (!ready_of(id) && cycles < 40);
        drive_req(id, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput({tag, "_latency"}, 32'(cycles), 32'(exp_cycles));
        @(posedge clk); #1;
        checkOutput({tag, "_ready_pulse"}, 32'(ready_of(id)), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_cpu_rdata = '0;
        exp_dbg_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Hard stop if the sequence below ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive_req(REQ_CPU, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_req(REQ_DBG, 1'b0, 1'b0, 32'd0, 32'd0);
        bus4.cpu_req = 1'b0; bus4.cpu_we = 1'b0; bus4.cpu_addr = '0; bus4.cpu_wdata = '0;
        bus4.dbg_req = 1'b0; bus4.dbg_we = 1'b0; bus4.dbg_addr = '0; bus4.dbg_wdata = '0;
        for (int i = 0; i < 1024; i++) begin
            mem4[i] = 32'hCAFE_0000 | 32'(i);
        end
        exp_cpu_rdata = '0;
        exp_dbg_rdata = '0;

        #12;
        checkOutput("rst_cpu_ready", 32'(bus1.cpu_ready), 32'd0);
        checkOutput("rst_dbg_ready", 32'(bus1.dbg_ready), 32'd0);
        checkOutput("rst_mem_en", 32'(bus1.mem_en), 32'd0);
        checkOutput("rst_mem_we", 32'(bus1.mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(bus1.mem_addr), 32'd0);
        checkOutput("rst_cpu_rdata", bus1.cpu_rdata, 32'd0);
        checkOutput("rst_err", 32'(bus1.err_misalign), 32'd0);
        checkOutput("rst_state", 32'(dut1.state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;

        en_base = en_cnt;
        applyStimulus("cpu_store", REQ_CPU, 1'b1, 32'd56, 32'h000f_0000, 3);
        checkOutput("store_mem_en_count", 32'(en_cnt - en_base), 32'd1);
        checkOutput("store_mem_we", 32'(last_we), 32'd1);
        checkOutput("store_mem_addr", 32'(last_addr), 32'd14);
        checkOutput("store_mem_wdata", last_wdata, 32'h000f_0000);

        applyStimulus("dbg_store", REQ_DBG, 1'b1, 32'h100, 32'hDEAD_BEEF, 3);
        dbg_base = dbg_ready_cnt;
        applyStimulus("cpu_load", REQ_CPU, 1'b0, 32'h100, 32'd0, 3);
        checkOutput("cpu_load_no_dbg_ready", 32'(dbg_ready_cnt - dbg_base), 32'd0);
        applyStimulus("cpu_load_wrap", REQ_CPU, 1'b0, 32'h8000_1100, 32'd0, 3);
        applyStimulus("dbg_store_top", REQ_DBG, 1'b1, 32'hFFC, 32'h1234_5678, 3);
        applyStimulus("cpu_load_top", REQ_CPU, 1'b0, 32'hFFC, 32'd0, 3);

        checkOutput("err_before_misalign", 32'(bus1.err_misalign), 32'd0);
        en_base = en_cnt;
        applyStimulus("misalign_load", REQ_CPU, 1'b0, 32'h3, 32'd0, 1);
        checkOutput("misalign_no_mem_en", 32'(en_cnt - en_base), 32'd0);
        checkOutput("misalign_err", 32'(bus1.err_misalign), 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                applyStimulus("post_mis_store", REQ_DBG, 1'b1, 32'(32'h200 + 4 * i),
                              32'(32'h1000 + i), 3);
            end else begin
                applyStimulus("post_mis_load", REQ_CPU, 1'b0, 32'(32'h200 + 4 * (i - 1)),
                              32'd0, 3);
            end
        end
        checkOutput("misalign_sticky", 32'(bus1.err_misalign), 32'd1);

        // MEM_LAT=4 instance: request dropped (and address changed) right after grant.
        @(negedge clk);
        bus4.cpu_req = 1'b1; bus4.cpu_we = 1'b0; bus4.cpu_addr = 32'h14;
        @(posedge clk); #1;
        cyc = 1;
        bus4.cpu_req = 1'b0; bus4.cpu_addr = 32'h40;
        while (!bus4.cpu_ready && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("lat4_latency", 32'(cyc), 32'd6);
        checkOutput("lat4_rdata", bus4.cpu_rdata, 32'hCAFE_0005);
        checkOutput("lat4_dbg_ready", 32'(bus4.dbg_ready), 32'd0);
        @(posedge clk); #1;
        checkOutput("lat4_ready_pulse", 32'(bus4.cpu_ready), 32'd0);

        // Both ports request at once and hold their requests for two accesses.
        pulse_reset();
        checkOutput("rst_clears_err", 32'(bus1.err_misalign), 32'd0);
        @(negedge clk);
`ifdef DMEM_ARB_RR_EN
        expect_access(REQ_CPU, 1'b0, 32'd56, 32'd0);
        expect_access(REQ_DBG, 1'b0, 32'h100, 32'd0);
`else
        expect_access(REQ_DBG, 1'b0, 32'h100, 32'd0);
        expect_access(REQ_DBG, 1'b0, 32'h100, 32'd0);
`endif
        drive_req(REQ_CPU, 1'b1, 1'b0, 32'd56, 32'd0);
        drive_req(REQ_DBG, 1'b1, 1'b0, 32'h100, 32'd0);
        pulses = 0;
        cyc    = 0;
        while (pulses < 2 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (bus1.cpu_ready || bus1.dbg_ready) pulses++;
        end
        drive_req(REQ_CPU, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_req(REQ_DBG, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("sim_pulses", 32'(pulses), 32'd2);
        checkOutput("sim_cycles", 32'(cyc), 32'd7);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("sim_sb_drained", 32'(sb_q.size()), 32'd0);

        // Reset lands in the first ACCESS cycle of a CPU load.
        @(negedge clk);
        drive_req(REQ_CPU, 1'b1, 1'b0, 32'd56, 32'd0);
        @(posedge clk); #1;
        checkOutput("abort_mem_en_before", 32'(bus1.mem_en), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort_cpu_ready", 32'(bus1.cpu_ready), 32'd0);
        checkOutput("abort_dbg_ready", 32'(bus1.dbg_ready), 32'd0);
        checkOutput("abort_mem_en", 32'(bus1.mem_en), 32'd0);
        checkOutput("abort_mem_addr", 32'(bus1.mem_addr), 32'd0);
        checkOutput("abort_mem_wdata", bus1.mem_wdata, 32'd0);
        checkOutput("abort_cpu_rdata", bus1.cpu_rdata, 32'd0);
        checkOutput("abort_dbg_rdata", bus1.dbg_rdata, 32'd0);
        checkOutput("abort_state", 32'(dut1.state), 32'(IDLE));
        exp_cpu_rdata = '0;
        exp_dbg_rdata = '0;
        drive_req(REQ_CPU, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("abort_sb_empty", 32'(sb_q.size()), 32'd0);
        applyStimulus("after_abort_load", REQ_CPU, 1'b0, 32'd56, 32'd0, 3);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("final_sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
